// File: rtl/instruction_fetch_unit.sv
// Fetch stage: five byte reads per 40-bit instruction, pc ownership and jump redirect; 6 cycles first read to ins_valid.
// Backpressure: instruction is held with mem_rd idle while ins_valid && !ins_ready; next fetch issues the cycle after acceptance.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_identifier,
  output logic [15:0] argument1,
  output logic [15:0] argument2,
  output logic [15:0] ins_pc,
  input  logic        jump_valid,
  input  logic [15:0] jump_target,
  output logic [15:0] pc
);

  typedef enum logic {FETCH, HOLD} stateT;

  stateT       state;
  stateT       stateNext;
  logic [2:0]  issueCnt;
  logic [2:0]  captureCnt;
  logic        dataValid;
  logic        accept;
  logic        restart;
  logic        doIssue;
  logic        captureByte;
  logic        lastByte;
  logic [2:0]  issueIdx;
  logic [15:0] pcNext;
  logic [15:0] baseNext;
  logic [15:0] fetchAddr;

  assign ins_valid = (state == HOLD);

  always_comb begin
    accept      = ins_valid && ins_ready;
    restart     = jump_valid || accept;
    pcNext      = pc;
    if (jump_valid) begin
      pcNext = jump_target;
    end else if (accept) begin
      pcNext = pc + 16'd1;
    end
    // A byte arriving on a jump edge belongs to the abandoned fetch.
    captureByte = (state == FETCH) && dataValid && !jump_valid;
    lastByte    = captureByte && (captureCnt == 3'd4);
    doIssue     = restart || ((state == FETCH) && (issueCnt < 3'd5));
    issueIdx    = restart ? 3'd0 : issueCnt;
    baseNext    = {pcNext[13:0], 2'b00} + pcNext;
    fetchAddr   = baseNext + {13'd0, issueIdx};
    stateNext   = state;
    if (restart) begin
      stateNext = FETCH;
    end else if (lastByte) begin
      stateNext = HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_PC;
      issueCnt       <= 3'd0;
      captureCnt     <= 3'd0;
      dataValid      <= 1'b0;
      mem_rd         <= 1'b0;
      mem_addr       <= 16'd0;
      ins_identifier <= 8'd0;
      argument1      <= 16'd0;
      argument2      <= 16'd0;
      ins_pc         <= 16'd0;
    end else begin
      pc        <= pcNext;
      mem_rd    <= doIssue;
      dataValid <= mem_rd && !jump_valid;
      if (doIssue) begin
        mem_addr <= fetchAddr;
        issueCnt <= issueIdx + 3'd1;
      end
      if (restart) begin
        captureCnt <= 3'd0;
      end else if (captureByte) begin
        captureCnt <= captureCnt + 3'd1;
        case (captureCnt)
          3'd0: begin
            ins_identifier <= mem_data;
            ins_pc         <= pc;
          end
          3'd1: argument1[15:8] <= mem_data;
          3'd2: argument1[7:0]  <= mem_data;
          3'd3: argument2[15:8] <= mem_data;
          3'd4: argument2[7:0]  <= mem_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: byte ROM model, timing/content reference model, directed table and random traffic.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_identifier;
  logic [15:0] argument1;
  logic [15:0] argument2;
  logic [15:0] ins_pc;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic [15:0] pc;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_identifier(ins_identifier),
    .argument1(argument1), .argument2(argument2), .ins_pc(ins_pc),
    .jump_valid(jump_valid), .jump_target(jump_target), .pc(pc)
  );

  logic [7:0] rom [65536];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_data <= rom[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: pc plus age, the cycle count since the current fetch began (cycle T = 0).
  logic [15:0] mPc;
  int          mAge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkModel();
    logic [15:0] base;
    logic [15:0] a;
    base = mPc * 16'd5;
    chk("pc", {16'd0, pc}, {16'd0, mPc});
    chk("ins_valid", {31'd0, ins_valid}, {31'd0, (mAge >= 6)});
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, (mAge >= 0 && mAge <= 4)});
    if (mAge >= 0 && mAge <= 4) begin
      a = base + 16'(mAge);
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
    end
    if (mAge >= 6) begin
      chk("ins_identifier", {24'd0, ins_identifier}, {24'd0, rom[base]});
      chk("argument1", {16'd0, argument1}, {16'd0, rom[base + 16'd1], rom[base + 16'd2]});
      chk("argument2", {16'd0, argument2}, {16'd0, rom[base + 16'd3], rom[base + 16'd4]});
      chk("ins_pc", {16'd0, ins_pc}, {16'd0, mPc});
    end
  endtask

  task automatic step(input logic r, input logic jv, input logic [15:0] jt, input logic rdy);
    reset       = r;
    jump_valid  = jv;
    jump_target = jt;
    ins_ready   = rdy;
    if (r) begin
      mPc  = RESET_PC;
      mAge = -1;
    end else if (jv) begin
      mPc  = jt;
      mAge = 0;
    end else if (mAge >= 6 && rdy) begin
      mPc  = mPc + 16'd1;
      mAge = 0;
    end else if (mAge < 100) begin
      mAge++;
    end
    @(posedge clock);
    @(negedge clock);
    checkModel();
  endtask

  typedef struct {
    logic [15:0] target;
    logic [15:0] base;
    logic [39:0] bytesIn;
    logic [7:0]  expOp;
    logic [15:0] expA1;
    logic [15:0] expA2;
    logic [15:0] nextPc;
    logic [15:0] nextAddr;
  } vecT;

  vecT vecs [4];

  initial begin
    logic [15:0] a;
    vecs[0] = '{16'hFFFF, 16'hFFFB, 40'h5A01020304, 8'h5A, 16'h0102, 16'h0304, 16'h0000, 16'h0000};
    vecs[1] = '{16'h3333, 16'hFFFF, 40'hC3FEDCBA98, 8'hC3, 16'hFEDC, 16'hBA98, 16'h3334, 16'h0004};
    vecs[2] = '{16'h0001, 16'h0005, 40'h1122334455, 8'h11, 16'h2233, 16'h4455, 16'h0002, 16'h000A};
    vecs[3] = '{16'h8000, 16'h8000, 40'h8000FFFF7E, 8'h80, 16'h00FF, 16'hFF7E, 16'h8001, 16'h8005};

    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h09; rom[1] = 8'h12; rom[2] = 8'h34; rom[3] = 8'hAB; rom[4] = 8'hCD;
    reset = 1'b1; jump_valid = 1'b0; jump_target = 16'd0; ins_ready = 1'b0;
    mPc = RESET_PC; mAge = -1;

    // Reset values, then first fetch with ready held high.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_fields", {ins_identifier, argument1, 8'd0}, 32'd0);
    chk("rst_ins_pc", {16'd0, ins_pc, pc}, 32'd0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1);
    chk("first_op", {24'd0, ins_identifier}, 32'h09);
    chk("first_a1", {16'd0, argument1}, 32'h1234);
    chk("first_a2", {16'd0, argument2}, 32'hABCD);
    chk("first_ins_pc", {16'd0, ins_pc}, 32'h0);
    step(0, 0, 0, 1);
    chk("first_next_pc", {16'd0, pc}, 32'd1);
    chk("first_next_addr", {16'd0, mem_addr}, 32'd5);

    // Decoder stalls for 10 cycles in HOLD.
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    chk("stall_pc", {16'd0, pc}, 32'd1);
    step(0, 0, 0, 1);
    chk("stall_one_accept", {16'd0, pc}, 32'd2);
    chk("stall_refetch", {31'd0, mem_rd}, 32'd1);

    // Jump while byte 2 is being read.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 16'h0010, 1);
    chk("jmp_addr0", {16'd0, mem_addr}, 32'h0050);
    step(0, 0, 0, 0);
    chk("jmp_addr1", {16'd0, mem_addr}, 32'h0051);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    chk("jmp_ins_pc", {16'd0, ins_pc}, 32'h0010);

    // Jump coinciding with a handshake: target wins over pc+1.
    step(0, 1, 16'h0100, 1);
    chk("jmp_hs_pc", {16'd0, pc}, 32'h0100);
    chk("jmp_hs_addr", {16'd0, mem_addr}, 32'h0500);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("jmp_hs_next_pc", {16'd0, pc}, 32'h0101);

    // Directed redirect table, including address wrap cases.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 5; k++) begin
        a = vecs[i].base + 16'(k);
        rom[a] = vecs[i].bytesIn[39 - 8*k -: 8];
      end
      step(0, 1, vecs[i].target, 1);
      chk("vec_base", {16'd0, mem_addr}, {16'd0, vecs[i].base});
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
      chk("vec_op", {24'd0, ins_identifier}, {24'd0, vecs[i].expOp});
      chk("vec_a1", {16'd0, argument1}, {16'd0, vecs[i].expA1});
      chk("vec_a2", {16'd0, argument2}, {16'd0, vecs[i].expA2});
      chk("vec_ins_pc", {16'd0, ins_pc}, {16'd0, vecs[i].target});
      step(0, 0, 0, 1);
      chk("vec_next_pc", {16'd0, pc}, {16'd0, vecs[i].nextPc});
      chk("vec_next_addr", {16'd0, mem_addr}, {16'd0, vecs[i].nextAddr});
    end

    // Reset during the 4th read of a fetch.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("midrst_ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("midrst_fields", {ins_identifier, argument1, 8'd0}, 32'd0);
    chk("midrst_pc", {16'd0, pc, ins_pc}, {RESET_PC, 16'd0});
    step(0, 0, 0, 1);
    chk("midrst_refetch", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, RESET_PC * 16'd5});

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic r, jv, rdy;
      logic [15:0] jt;
      r   = ($urandom_range(0, 199) == 0);
      jv  = ($urandom_range(0, 24) == 0);
      jt  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, jv, jt, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
